// File: rtl/adc_spi_reader.sv
// SPI ADC frame reader: one FRAME_BITS-clock read per adc_clk rising edge, result on data with a 1-cycle data_valid.
// Latency adc_clk edge -> data_valid = 3 + CLK_DIV*(2*FRAME_BITS+2) cycles; requests during a frame are dropped and flagged on overrun.
module adc_spi_reader #(
   parameter int CLK_DIV    = 25,
   parameter int FRAME_BITS = 16,
   parameter int DATA_BITS  = 12
) (
   input  logic                 clk_in,
   input  logic                 clk_rst,
   input  logic                 enable,
   input  logic                 adc_clk,
   input  logic                 miso,
   output logic                 cs_n,
   output logic                 sclk,
   output logic [DATA_BITS-1:0] data,
   output logic                 data_valid,
   output logic                 overrun
);
   localparam int CW = $clog2(CLK_DIV);
   localparam int BW = $clog2(FRAME_BITS + 1);

   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;

   state_t               state_q, state_d;
   logic [CW-1:0]        hcnt_q, hcnt_d;
   logic [BW-1:0]        bcnt_q, bcnt_d;
   logic                 half_q, half_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic                 s1_q, s2_q, s3_q;
   logic                 cs_n_q, cs_n_d;
   logic                 sclk_q, sclk_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 valid_q, valid_d;
   logic                 ovr_q, ovr_d;
   logic                 req, hc_last, last_bit;

   assign req      = s2_q & ~s3_q;
   assign hc_last  = (hcnt_q == CW'(CLK_DIV - 1));
   assign last_bit = half_q && (bcnt_q == BW'(FRAME_BITS - 1));

   assign cs_n       = cs_n_q;
   assign sclk       = sclk_q;
   assign data       = data_q;
   assign data_valid = valid_q;
   assign overrun    = ovr_q;

   always_ff @(posedge clk_in or posedge clk_rst) begin
      if (clk_rst) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (!enable) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (req) state_d = SETUP;
            SETUP:   if (hc_last) state_d = SHIFT;
            SHIFT:   if (hc_last && last_bit) state_d = HOLD;
            HOLD:    if (hc_last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // Pin outputs follow the registered state one cycle later; enable=0 forces idle levels on the next edge.
   always_comb begin
      cs_n_d  = !(enable && (state_q == SETUP || state_q == SHIFT));
      sclk_d  = !(enable && state_q == SHIFT && !half_q);
      valid_d = enable && (state_q == DONE);
      ovr_d   = enable && req && (state_q != IDLE);
   end

   always_comb begin
      hcnt_d = '0;
      half_d = 1'b0;
      bcnt_d = '0;
      if (enable && (state_q == SETUP || state_q == SHIFT || state_q == HOLD))
         hcnt_d = hc_last ? '0 : hcnt_q + CW'(1);
      if (enable && state_q == SHIFT) begin
         half_d = hc_last ? ~half_q : half_q;
         bcnt_d = (hc_last && half_q) ? bcnt_q + BW'(1) : bcnt_q;
      end
      // Only the trailing DATA_BITS of the frame survive, so the shifter is no wider than the result.
      shreg_d = shreg_q;
      if (enable && state_q == SHIFT && !sclk_q && sclk_d)
         shreg_d = {shreg_q[DATA_BITS-2:0], miso};
      data_d = valid_d ? shreg_q : data_q;
   end

   always_ff @(posedge clk_in or posedge clk_rst) begin
      if (clk_rst) begin
         hcnt_q  <= '0;
         bcnt_q  <= '0;
         half_q  <= 1'b0;
         shreg_q <= '0;
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         s3_q    <= 1'b0;
         cs_n_q  <= 1'b1;
         sclk_q  <= 1'b1;
         data_q  <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         hcnt_q  <= hcnt_d;
         bcnt_q  <= bcnt_d;
         half_q  <= half_d;
         shreg_q <= shreg_d;
         s1_q    <= adc_clk;
         s2_q    <= s1_q;
         s3_q    <= s2_q;
         cs_n_q  <= cs_n_d;
         sclk_q  <= sclk_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
      end
   end
endmodule

// File: tb/tb_adc_spi_reader.sv
// Directed bench for adc_spi_reader: default instance (25/16/12) plus a small instance (2/8/8).
// Each DUT is driven by a behavioural ADC that shifts a frame word out MSB-first on sclk falling edges.
module tb_adc_spi_reader;
   logic        clk_in  = 1'b0;
   logic        clk_rst = 1'b1;
   logic        enable  = 1'b0;
   logic        adc_clk = 1'b0;
   logic        miso;
   logic        cs_n, sclk, data_valid, overrun;
   logic [11:0] data;

   logic        s_enable  = 1'b0;
   logic        s_adc_clk = 1'b0;
   logic        s_miso;
   logic        s_cs_n, s_sclk, s_data_valid, s_overrun;
   logic [7:0]  s_data;

   int n_pass  = 0;
   int n_total = 0;

   always #10 clk_in = ~clk_in;

   adc_spi_reader dut (
      .clk_in(clk_in), .clk_rst(clk_rst), .enable(enable), .adc_clk(adc_clk), .miso(miso),
      .cs_n(cs_n), .sclk(sclk), .data(data), .data_valid(data_valid), .overrun(overrun)
   );

   adc_spi_reader #(.CLK_DIV(2), .FRAME_BITS(8), .DATA_BITS(8)) dut_s (
      .clk_in(clk_in), .clk_rst(clk_rst), .enable(s_enable), .adc_clk(s_adc_clk), .miso(s_miso),
      .cs_n(s_cs_n), .sclk(s_sclk), .data(s_data), .data_valid(s_data_valid), .overrun(s_overrun)
   );

   logic [15:0] adc_word = '0;
   int          adc_idx  = 0;
   logic        cs_prev = 1'b1, sclk_prev = 1'b1;
   always @(cs_n or sclk) begin
      if (!cs_n && cs_prev) adc_idx = 16;
      if (!sclk && sclk_prev && !cs_n && adc_idx > 0) begin
         adc_idx = adc_idx - 1;
         miso    = adc_word[adc_idx];
      end
      cs_prev   = cs_n;
      sclk_prev = sclk;
   end

   logic [7:0] s_adc_word = '0;
   int         s_adc_idx  = 0;
   logic       s_cs_prev = 1'b1, s_sclk_prev = 1'b1;
   always @(s_cs_n or s_sclk) begin
      if (!s_cs_n && s_cs_prev) s_adc_idx = 8;
      if (!s_sclk && s_sclk_prev && !s_cs_n && s_adc_idx > 0) begin
         s_adc_idx = s_adc_idx - 1;
         s_miso    = s_adc_word[s_adc_idx];
      end
      s_cs_prev   = s_cs_n;
      s_sclk_prev = s_sclk;
   end

   task automatic chk(input string name, input int got, input int exp);
      n_total++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
   endtask

   int          r_lat_cs, r_lat_v, r_nv, r_rises, r_gap, r_ncsf, r_novr;
   logic [11:0] r_data;

   // Raise adc_clk just before edge N (k=0 is the sample after edge N) and watch the frame.
   task automatic run_frame(input bit sm, input logic [15:0] word,
                            input int ovr_at, input int abort_at, input int rst_at);
      int   len, last_csr;
      logic cs, sc, dv, ov, pcs, psc;
      len = sm ? 60 : 880;
      r_lat_cs = -1; r_lat_v = -1; r_nv = 0; r_rises = 0; r_gap = -1; r_ncsf = 0; r_novr = 0;
      last_csr = -1000;
      if (sm) s_adc_word = word[7:0];
      else    adc_word   = word;
      @(negedge clk_in);
      if (sm) s_adc_clk = 1'b1;
      else    adc_clk   = 1'b1;
      pcs = 1'b1;
      psc = 1'b1;
      for (int k = 0; k < len; k++) begin
         @(posedge clk_in);
         #1;
         cs = sm ? s_cs_n       : cs_n;
         sc = sm ? s_sclk       : sclk;
         dv = sm ? s_data_valid : data_valid;
         ov = sm ? s_overrun    : overrun;
         if (!cs && pcs) begin
            r_ncsf++;
            if (r_lat_cs < 0) r_lat_cs = k;
         end
         if (cs && !pcs) last_csr = k;
         if (sc && !psc && !cs) r_rises++;
         if (dv) begin
            r_nv++;
            r_lat_v = k;
            r_gap   = k - last_csr;
         end
         if (ov) r_novr++;
         if (abort_at >= 0 && k == abort_at + 1) begin
            chk("abort_cs_n", int'(cs), 1);
            chk("abort_sclk", int'(sc), 1);
         end
         if (k == 100) adc_clk = 1'b0;
         if (k == ovr_at) adc_clk = 1'b1;
         if (k == abort_at) enable = 1'b0;
         if (k == rst_at) begin
            clk_rst = 1'b1;
            #2;
            chk("rst_cs_n", int'(cs_n), 1);
            chk("rst_sclk", int'(sclk), 1);
            chk("rst_data", int'(data), 0);
            chk("rst_valid", int'(data_valid), 0);
            clk_rst = 1'b0;
         end
         pcs = cs;
         psc = sc;
      end
      r_data    = sm ? {4'h0, s_data} : data;
      adc_clk   = 1'b0;
      s_adc_clk = 1'b0;
      enable    = 1'b1;
      s_enable  = 1'b1;
      repeat (5) @(posedge clk_in);
   endtask

   typedef struct {
      bit          sm;
      logic [15:0] word;
      logic [11:0] exp_data;
      int          exp_lat;
      int          exp_rises;
      int          exp_gap;
   } vec_t;

   vec_t vecs [6];
   int   lows;

   initial begin
      vecs[0] = '{1'b0, 16'h0ABC, 12'hABC, 853, 16, 25};
      vecs[1] = '{1'b0, 16'hFFFF, 12'hFFF, 853, 16, 25};
      vecs[2] = '{1'b0, 16'h0000, 12'h000, 853, 16, 25};
      vecs[3] = '{1'b0, 16'hC35A, 12'h35A, 853, 16, 25};
      vecs[4] = '{1'b1, 16'h00A5, 12'h0A5, 39, 8, 2};
      vecs[5] = '{1'b1, 16'h003C, 12'h03C, 39, 8, 2};

      repeat (3) @(posedge clk_in);
      #1;
      chk("reset_cs_n", int'(cs_n), 1);
      chk("reset_sclk", int'(sclk), 1);
      chk("reset_data", int'(data), 0);
      chk("reset_valid", int'(data_valid), 0);
      chk("reset_overrun", int'(overrun), 0);
      chk("reset_s_cs_n", int'(s_cs_n), 1);
      chk("reset_s_data", int'(s_data), 0);
      @(negedge clk_in);
      clk_rst  = 1'b0;
      enable   = 1'b1;
      s_enable = 1'b1;
      repeat (5) @(posedge clk_in);

      for (int i = 0; i < 6; i++) begin
         run_frame(vecs[i].sm, vecs[i].word, -1, -1, -1);
         chk($sformatf("vec%0d_data", i), int'(r_data), int'(vecs[i].exp_data));
         chk($sformatf("vec%0d_valid_lat", i), r_lat_v, vecs[i].exp_lat);
         chk($sformatf("vec%0d_valid_cnt", i), r_nv, 1);
         chk($sformatf("vec%0d_cs_lat", i), r_lat_cs, 3);
         chk($sformatf("vec%0d_sclk_rises", i), r_rises, vecs[i].exp_rises);
         chk($sformatf("vec%0d_cs_high_gap", i), r_gap, vecs[i].exp_gap);
      end

      // Second request 300 cycles into the frame.
      run_frame(1'b0, 16'h0123, 300, -1, -1);
      chk("ovr_count", r_novr, 1);
      chk("ovr_valid_cnt", r_nv, 1);
      chk("ovr_frames", r_ncsf, 1);
      chk("ovr_data", int'(r_data), 12'h123);
      chk("ovr_valid_lat", r_lat_v, 853);

      // enable dropped during bit 7 of SHIFT.
      run_frame(1'b0, 16'h0FED, -1, 390, -1);
      chk("abort_valid_cnt", r_nv, 0);
      chk("abort_data_held", int'(r_data), 12'h123);
      run_frame(1'b0, 16'h0456, -1, -1, -1);
      chk("post_abort_data", int'(r_data), 12'h456);
      chk("post_abort_rises", r_rises, 16);

      // Asynchronous reset during SHIFT.
      run_frame(1'b0, 16'h0789, -1, -1, 400);
      chk("rst_valid_cnt", r_nv, 0);
      chk("rst_frames", r_ncsf, 1);
      chk("rst_data_after", int'(r_data), 0);
      run_frame(1'b0, 16'h0321, -1, -1, -1);
      chk("post_rst_data", int'(r_data), 12'h321);

      // enable rising while adc_clk is already high must not start a frame.
      enable = 1'b0;
      @(negedge clk_in);
      adc_clk = 1'b1;
      repeat (10) @(posedge clk_in);
      @(negedge clk_in);
      enable = 1'b1;
      lows = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk_in);
         #1;
         if (!cs_n || overrun) lows++;
      end
      chk("en_rise_no_frame", lows, 0);
      adc_clk = 1'b0;
      repeat (5) @(posedge clk_in);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
